// File: rtl/dmem_ctrl_pkg.sv
// Shared RV32I data-memory definitions: access-size codes, controller
// FSM state type and the alignment rule used to reject bad accesses.
package dmem_ctrl_pkg;

    localparam int MEMORY_MODE_WIDTH = 2;

    localparam logic [MEMORY_MODE_WIDTH-1:0] MODE_BYTE = 2'b00;
    localparam logic [MEMORY_MODE_WIDTH-1:0] MODE_HALF = 2'b01;
    localparam logic [MEMORY_MODE_WIDTH-1:0] MODE_WORD = 2'b10;
    // 2'b11 is reserved and always rejected as misaligned.

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_REQ    = 2'b01,
        ST_WAIT_R = 2'b10,
        ST_DONE   = 2'b11
    } dmem_state_e;

    // True when the access cannot be issued: halfword on an odd address,
    // word not on a 4-byte boundary, or an unknown size code.
    function automatic logic is_misaligned(
        input logic [MEMORY_MODE_WIDTH-1:0] mode,
        input logic [1:0]                   off
    );
        logic bad;
        bad = 1'b0;
        case (mode)
            MODE_BYTE: bad = 1'b0;
            MODE_HALF: bad = off[0];
            MODE_WORD: bad = (off != 2'b00);
            default:   bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dmem_ctrl_align.sv
// Byte-lane steering for stores and extract/extend for loads.
// Purely combinational; the controller registers whatever it needs.
module dmem_align
    import dmem_ctrl_pkg::*;
(
    input  logic [MEMORY_MODE_WIDTH-1:0] i_st_mode,
    input  logic [1:0]                   i_st_off,
    input  logic [31:0]                  i_st_wdata,
    output logic [3:0]                   o_be,
    output logic [31:0]                  o_lane_wdata,
    input  logic [MEMORY_MODE_WIDTH-1:0] i_ld_mode,
    input  logic [1:0]                   i_ld_off,
    input  logic                         i_ld_unsigned,
    input  logic [31:0]                  i_ld_word,
    output logic [31:0]                  o_ld_data
);

    logic [15:0] w_shifted;

    // Store side: byte enables from size/offset, data replicated on every lane.
    always_comb begin
        o_be         = 4'b0000;
        o_lane_wdata = 32'h0000_0000;
        case (i_st_mode)
            MODE_BYTE: begin
                o_be         = 4'b0001 << i_st_off;
                o_lane_wdata = {4{i_st_wdata[7:0]}};
            end
            MODE_HALF: begin
                o_be         = 4'b0011 << {i_st_off[1], 1'b0};
                o_lane_wdata = {2{i_st_wdata[15:0]}};
            end
            MODE_WORD: begin
                o_be         = 4'b1111;
                o_lane_wdata = i_st_wdata;
            end
            default: begin
                o_be         = 4'b0000;
                o_lane_wdata = 32'h0000_0000;
            end
        endcase
    end

    // Load side: move the addressed byte/half to bit 0, then sign/zero extend.
    always_comb begin
        w_shifted = 16'(i_ld_word >> {i_ld_off, 3'b000});
        o_ld_data = 32'h0000_0000;
        case (i_ld_mode)
            MODE_BYTE: begin
                if (i_ld_unsigned) begin
                    o_ld_data = {24'h00_0000, w_shifted[7:0]};
                end else begin
                    o_ld_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
                end
            end
            MODE_HALF: begin
                if (i_ld_unsigned) begin
                    o_ld_data = {16'h0000, w_shifted};
                end else begin
                    o_ld_data = {{16{w_shifted[15]}}, w_shifted};
                end
            end
            MODE_WORD: o_ld_data = i_ld_word;
            default:   o_ld_data = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/dmem_ctrl.sv
// MEM-stage data memory controller: turns load/store requests into a
// req/gnt/rvalid bus transaction, stalling the pipeline until it completes,
// with misalignment rejection and a grant/read-data timeout.
module dmem_ctrl
    import dmem_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         mem_read,
    input  logic                         mem_write,
    input  logic [MEMORY_MODE_WIDTH-1:0] mem_mode,
    input  logic                         mem_unsigned,
    input  logic [31:0]                  addr,
    input  logic [31:0]                  wdata,
    output logic [31:0]                  rdata,
    output logic                         stall,
    output logic                         misaligned_err,
    output logic                         bus_err,
    output logic                         bus_req,
    output logic                         bus_we,
    output logic [31:0]                  bus_addr,
    output logic [3:0]                   bus_be,
    output logic [31:0]                  bus_wdata,
    input  logic                         bus_gnt,
    input  logic                         bus_rvalid,
    input  logic [31:0]                  bus_rdata
);

    // Counter only needs to reach TIMEOUT-1: that is the last cycle waited.
    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    dmem_state_e                  r_state;
    logic [CNT_W-1:0]             r_cnt;
    logic [31:0]                  r_rdata;
    logic                         r_bus_err;
    logic                         r_bus_req;
    logic                         r_bus_we;
    logic [31:0]                  r_bus_addr;
    logic [3:0]                   r_bus_be;
    logic [31:0]                  r_bus_wdata;
    logic [MEMORY_MODE_WIDTH-1:0] r_mode;
    logic [1:0]                   r_off;
    logic                         r_uns;

    logic                         w_access;
    logic                         w_misaligned;
    logic                         w_start;
    logic [3:0]                   w_be;
    logic [31:0]                  w_lane_wdata;
    logic [31:0]                  w_ld_data;

    // A write wins over a simultaneous read, so the request is a store whenever mem_write is set.
    assign w_access     = mem_read | mem_write;
    assign w_misaligned = is_misaligned(mem_mode, addr[1:0]);
    assign w_start      = (r_state == ST_IDLE) && w_access && !w_misaligned;

    // Stall must rise in the same cycle the request appears, so it is decoded from state
    // and the live request; reset forces it low immediately.
    assign stall          = !rst && (w_start || (r_state == ST_REQ) || (r_state == ST_WAIT_R));
    assign misaligned_err = !rst && (r_state == ST_IDLE) && w_access && w_misaligned;

    assign rdata     = r_rdata;
    assign bus_err   = r_bus_err;
    assign bus_req   = r_bus_req;
    assign bus_we    = r_bus_we;
    assign bus_addr  = r_bus_addr;
    assign bus_be    = r_bus_be;
    assign bus_wdata = r_bus_wdata;

    dmem_align u_align (
        .i_st_mode     (mem_mode),
        .i_st_off      (addr[1:0]),
        .i_st_wdata    (wdata),
        .o_be          (w_be),
        .o_lane_wdata  (w_lane_wdata),
        .i_ld_mode     (r_mode),
        .i_ld_off      (r_off),
        .i_ld_unsigned (r_uns),
        .i_ld_word     (bus_rdata),
        .o_ld_data     (w_ld_data)
    );

    // Transaction FSM: latch request, hold bus_req to grant, collect read data, abort on timeout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_rdata     <= 32'h0000_0000;
            r_bus_err   <= 1'b0;
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= 32'h0000_0000;
            r_bus_be    <= 4'b0000;
            r_bus_wdata <= 32'h0000_0000;
            r_mode      <= MODE_BYTE;
            r_off       <= 2'b00;
            r_uns       <= 1'b0;
        end else begin
            r_bus_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_state     <= ST_REQ;
                        r_cnt       <= '0;
                        r_bus_req   <= 1'b1;
                        r_bus_we    <= mem_write;
                        r_bus_addr  <= {addr[31:2], 2'b00};
                        r_bus_be    <= w_be;
                        r_bus_wdata <= w_lane_wdata;
                        r_mode      <= mem_mode;
                        r_off       <= addr[1:0];
                        r_uns       <= mem_unsigned;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_REQ: begin
                    if (bus_gnt) begin
                        r_bus_req <= 1'b0;
                        r_cnt     <= '0;
                        r_state   <= r_bus_we ? ST_DONE : ST_WAIT_R;
                    end else if (r_cnt == CNT_LAST) begin
                        r_bus_req <= 1'b0;
                        r_bus_err <= 1'b1;
                        if (!r_bus_we) begin
                            r_rdata <= 32'h0000_0000;
                        end else begin
                            r_rdata <= r_rdata;
                        end
                        r_state <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_WAIT_R: begin
                    if (bus_rvalid) begin
                        r_rdata <= w_ld_data;
                        r_state <= ST_DONE;
                    end else if (r_cnt == CNT_LAST) begin
                        r_rdata   <= 32'h0000_0000;
                        r_bus_err <= 1'b1;
                        r_state   <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl (TIMEOUT=4): stores, loads with extension,
// misalignment, timeout abort and reset in the middle of a load.
module tb_dmem_ctrl;
    import dmem_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read, mem_write, mem_unsigned;
    logic [1:0]  mem_mode;
    logic [31:0] addr, wdata, rdata, bus_addr, bus_wdata, bus_rdata;
    logic        stall, misaligned_err, bus_err, bus_req, bus_we;
    logic [3:0]  bus_be;
    logic        bus_gnt, bus_rvalid;

    int checks   = 0;
    int failures = 0;

    dmem_ctrl #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
        .mem_mode(mem_mode), .mem_unsigned(mem_unsigned), .addr(addr), .wdata(wdata),
        .rdata(rdata), .stall(stall), .misaligned_err(misaligned_err), .bus_err(bus_err),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
        .bus_wdata(bus_wdata), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic idle_inputs();
        mem_read = 1'b0; mem_write = 1'b0; mem_unsigned = 1'b0; mem_mode = MODE_WORD;
        addr = 32'h0; wdata = 32'h0; bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'h0;
    endtask

    // Load with grant in first REQ cycle and rvalid in first WAIT_R cycle.
    task automatic run_load(input logic [1:0] mode, input logic uns, input logic [31:0] a,
                            input logic [31:0] rd, output logic [3:0] be_seen,
                            output logic stall_done);
        @(negedge clk); mem_read = 1'b1; mem_mode = mode; mem_unsigned = uns; addr = a; #1;
        @(negedge clk); #1; be_seen = bus_be; bus_gnt = 1'b1;
        @(negedge clk); bus_gnt = 1'b0; bus_rdata = rd; bus_rvalid = 1'b1; #1;
        @(negedge clk); bus_rvalid = 1'b0; mem_read = 1'b0; #1; stall_done = stall;
        @(negedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; idle_inputs(); mem_read = 1'b1;
        @(negedge clk); #1;
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%0b want=0", stall); end
        checks++; if (bus_req !== 1'b0 || bus_we !== 1'b0) begin failures++; $display("FAIL reset_req got=%0b%0b want=00", bus_req, bus_we); end
        checks++; if (rdata !== 32'h0 || bus_addr !== 32'h0 || bus_wdata !== 32'h0 || bus_be !== 4'h0) begin
            failures++; $display("FAIL reset_data rdata=%h addr=%h wdata=%h be=%b want all zero", rdata, bus_addr, bus_wdata, bus_be); end
        checks++; if (bus_err !== 1'b0 || misaligned_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%0b%0b want=00", bus_err, misaligned_err); end
        mem_read = 1'b0; rst = 1'b0;
    endtask

    task automatic test_sw();
        int n_stall;
        n_stall = 0;
        @(negedge clk); mem_write = 1'b1; mem_mode = MODE_WORD; addr = 32'h104; wdata = 32'hDEADBEEF; #1;
        if (stall) n_stall++;
        checks++; if (bus_req !== 1'b0) begin failures++; $display("FAIL sw_idle_req got=%0b want=0", bus_req); end
        @(negedge clk); #1;
        if (stall) n_stall++;
        checks++; if (bus_req !== 1'b1 || bus_we !== 1'b1) begin failures++; $display("FAIL sw_req got req=%0b we=%0b want 11", bus_req, bus_we); end
        checks++; if (bus_be !== 4'b1111) begin failures++; $display("FAIL sw_be got=%b want=1111", bus_be); end
        checks++; if (bus_addr !== 32'h104) begin failures++; $display("FAIL sw_addr got=%h want=00000104", bus_addr); end
        checks++; if (bus_wdata !== 32'hDEADBEEF) begin failures++; $display("FAIL sw_wdata got=%h want=deadbeef", bus_wdata); end
        @(negedge clk); #1;
        if (stall) n_stall++;
        checks++; if (bus_req !== 1'b1) begin failures++; $display("FAIL sw_req_hold got=%0b want=1", bus_req); end
        bus_gnt = 1'b1;
        @(negedge clk); bus_gnt = 1'b0; #1;
        if (stall) n_stall++;
        checks++; if (n_stall != 3) begin failures++; $display("FAIL sw_stall_cycles got=%0d want=3", n_stall); end
        checks++; if (bus_req !== 1'b0 || bus_err !== 1'b0) begin failures++; $display("FAIL sw_done got req=%0b err=%0b want 00", bus_req, bus_err); end
        mem_write = 1'b0;
        @(negedge clk); #1;
        checks++; if (stall !== 1'b0 || bus_req !== 1'b0) begin failures++; $display("FAIL sw_idle_after got stall=%0b req=%0b want 00", stall, bus_req); end
    endtask

    task automatic test_loads();
        logic [3:0] be; logic sd;
        run_load(MODE_BYTE, 1'b0, 32'h203, 32'h80FF_1234, be, sd);
        checks++; if (be !== 4'b1000) begin failures++; $display("FAIL lb_be got=%b want=1000", be); end
        checks++; if (rdata !== 32'hFFFF_FF80) begin failures++; $display("FAIL lb_rdata got=%h want=ffffff80", rdata); end
        checks++; if (sd !== 1'b0) begin failures++; $display("FAIL lb_done_stall got=%0b want=0", sd); end
        run_load(MODE_BYTE, 1'b1, 32'h203, 32'h80FF_1234, be, sd);
        checks++; if (rdata !== 32'h0000_0080) begin failures++; $display("FAIL lbu_rdata got=%h want=00000080", rdata); end
        run_load(MODE_HALF, 1'b0, 32'h202, 32'h8001_0000, be, sd);
        checks++; if (be !== 4'b1100) begin failures++; $display("FAIL lh_be got=%b want=1100", be); end
        checks++; if (rdata !== 32'hFFFF_8001) begin failures++; $display("FAIL lh_rdata got=%h want=ffff8001", rdata); end
    endtask

    task automatic test_sh_and_hold();
        @(negedge clk); mem_write = 1'b1; mem_mode = MODE_HALF; addr = 32'h202; wdata = 32'h0000_1234; #1;
        @(negedge clk); #1;
        checks++; if (bus_be !== 4'b1100) begin failures++; $display("FAIL sh_be got=%b want=1100", bus_be); end
        checks++; if (bus_wdata !== 32'h1234_1234) begin failures++; $display("FAIL sh_wdata got=%h want=12341234", bus_wdata); end
        bus_gnt = 1'b1;
        @(negedge clk); bus_gnt = 1'b0; mem_write = 1'b0; #1;
        @(negedge clk); #1;
        checks++; if (rdata !== 32'hFFFF_8001) begin failures++; $display("FAIL rdata_hold got=%h want=ffff8001", rdata); end
    endtask

    task automatic test_rw_both();
        @(negedge clk); mem_write = 1'b1; mem_read = 1'b1; mem_mode = MODE_BYTE; addr = 32'h201; wdata = 32'h0000_00A5; #1;
        @(negedge clk); #1;
        checks++; if (bus_we !== 1'b1 || bus_be !== 4'b0010 || bus_wdata !== 32'hA5A5_A5A5) begin
            failures++; $display("FAIL rw_store got we=%0b be=%b wdata=%h want 1 0010 a5a5a5a5", bus_we, bus_be, bus_wdata); end
        bus_gnt = 1'b1;
        @(negedge clk); bus_gnt = 1'b0; #1;
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL rw_no_wait got stall=%0b want=0", stall); end
        mem_write = 1'b0; mem_read = 1'b0;
        @(negedge clk); #1;
    endtask

    task automatic test_misaligned();
        logic [1:0]  modes [3];
        logic [31:0] addrs [3];
        modes[0] = MODE_WORD; addrs[0] = 32'h101;
        modes[1] = MODE_HALF; addrs[1] = 32'h201;
        modes[2] = 2'b11;     addrs[2] = 32'h200;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); mem_read = 1'b1; mem_mode = modes[i]; addr = addrs[i]; #1;
            checks++; if (misaligned_err !== 1'b1 || stall !== 1'b0) begin
                failures++; $display("FAIL misalign_%0d got err=%0b stall=%0b want 1 0", i, misaligned_err, stall); end
            @(negedge clk); mem_read = 1'b0; #1;
            checks++; if (misaligned_err !== 1'b0 || bus_req !== 1'b0 || stall !== 1'b0) begin
                failures++; $display("FAIL misalign_after_%0d got err=%0b req=%0b stall=%0b want 000", i, misaligned_err, bus_req, stall); end
        end
    endtask

    task automatic test_timeout();
        int n_req; bit seen;
        n_req = 0; seen = 1'b0;
        @(negedge clk); mem_read = 1'b1; mem_mode = MODE_WORD; addr = 32'h300; #1;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk); #1;
            if (bus_err) begin
                seen = 1'b1;
                checks++; if (stall !== 1'b0) begin failures++; $display("FAIL to_done_stall got=%0b want=0", stall); end
                checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL to_rdata got=%h want=00000000", rdata); end
                mem_read = 1'b0;
            end else if (bus_req) begin
                n_req++;
            end
        end
        checks++; if (!seen) begin failures++; $display("FAIL to_bus_err got=none want=pulse"); end
        checks++; if (n_req != 4) begin failures++; $display("FAIL to_req_cycles got=%0d want=4", n_req); end
        mem_read = 1'b0;
        @(negedge clk); #1;
        checks++; if (bus_err !== 1'b0) begin failures++; $display("FAIL to_pulse got=%0b want=0", bus_err); end
    endtask

    task automatic test_reset_mid();
        logic [3:0] be; logic sd;
        run_load(MODE_BYTE, 1'b1, 32'h200, 32'h0000_0077, be, sd);
        @(negedge clk); mem_read = 1'b1; mem_mode = MODE_WORD; addr = 32'h400; #1;
        @(negedge clk); bus_gnt = 1'b1; #1;
        @(negedge clk); bus_gnt = 1'b0; rst = 1'b1; #1;
        checks++; if (stall !== 1'b0 || bus_req !== 1'b0 || rdata !== 32'h0 || bus_addr !== 32'h0 || bus_be !== 4'h0) begin
            failures++; $display("FAIL rstmid_zero got stall=%0b req=%0b rdata=%h addr=%h be=%b want zeros", stall, bus_req, rdata, bus_addr, bus_be); end
        @(negedge clk); rst = 1'b0; mem_read = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'hAAAA_5555; #1;
        @(negedge clk); bus_rvalid = 1'b0; #1;
        checks++; if (rdata !== 32'h0 || bus_err !== 1'b0 || stall !== 1'b0 || bus_req !== 1'b0) begin
            failures++; $display("FAIL rstmid_late got rdata=%h err=%0b stall=%0b req=%0b want 0 0 0 0", rdata, bus_err, stall, bus_req); end
        run_load(MODE_WORD, 1'b0, 32'h500, 32'h1357_9BDF, be, sd);
        checks++; if (rdata !== 32'h1357_9BDF || be !== 4'b1111) begin
            failures++; $display("FAIL rstmid_next got rdata=%h be=%b want 13579bdf 1111", rdata, be); end
    endtask

    initial begin
        test_reset();
        test_sw();
        test_loads();
        test_sh_and_hold();
        test_rw_both();
        test_misaligned();
        test_timeout();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 Parameter TIMEOUT, 255: max cycles waited for bus_gnt or bus_rvalid before abort.
REQ-002 clk  in  1  single clock; all state on rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 mem_read  in  1  MEM-stage load request (from decoded D_MEM_read).
REQ-005 mem_write  in  1  MEM-stage store request (from decoded D_MEM_write).
REQ-006 mem_mode  in  MEMORY_MODE_WIDTH  BYTE/HALFWORD/WORD access size.
REQ-007 mem_unsigned  in  1  zero-extend load data (LBU/LHU) when 1, sign-extend when 0.
REQ-008 addr  in  32  byte address from ALU.
REQ-009 wdata  in  32  store data, right-aligned.
REQ-010 rdata  out  32  aligned and extended load result.
REQ-011 stall  out  1  freeze IF..MEM pipeline registers while high.
REQ-012 misaligned_err  out  1  one-cycle pulse, access rejected.
REQ-013 bus_err  out  1  one-cycle pulse, access aborted on timeout.
REQ-014 bus_req, bus_we  out  1 each  bus request and write qualifier.
REQ-015 bus_addr  out  32  word-aligned address (addr[1:0] forced to 0).
REQ-016 bus_be  out  4  byte enables; bus_wdata  out  32  lane-replicated store data.
REQ-017 bus_gnt, bus_rvalid  in  1 each; bus_rdata  in  32  bus handshake and read word.

Function
REQ-018 FSM states IDLE, REQ, WAIT_R, DONE; encoding free.
REQ-019 IDLE: a valid aligned request latches addr, be, wdata, we, mode, unsigned and moves to REQ next cycle.
REQ-020 stall SHALL be high in IDLE with a valid aligned request, and in REQ and WAIT_R; low in DONE.
REQ-021 REQ: bus_req high with latched fields stable until bus_gnt; on gnt, store -> DONE, load -> WAIT_R.
REQ-022 WAIT_R: on bus_rvalid capture bus_rdata, align and extend into rdata, -> DONE.
REQ-023 DONE: one cycle, stall low so the pipeline advances; requests present this cycle are ignored; -> IDLE.
REQ-024 bus_be: BYTE 4'b0001<<addr[1:0]; HALFWORD 4'b0011<<{addr[1],1'b0}; WORD 4'b1111.
REQ-025 bus_wdata: BYTE wdata[7:0] replicated x4; HALFWORD wdata[15:0] x2; WORD as-is.
REQ-026 Load data shifted right by addr[1:0]*8, then byte/half extended per mem_unsigned; WORD unmodified.
REQ-027 rdata holds its value until the next load completes.
REQ-028 Misaligned (HALFWORD with addr[0]=1, WORD with addr[1:0]!=0, or reserved mode code): no bus access, no stall, misaligned_err high combinationally for that IDLE cycle.
REQ-029 mem_read and mem_write both high: treated as store; load ignored.
REQ-030 A wait counter clears on entry to REQ and WAIT_R and increments each cycle there; at TIMEOUT: drop bus_req, bus_err pulse, rdata=0 for loads, -> DONE.
REQ-031 bus_gnt outside REQ and bus_rvalid outside WAIT_R SHALL be ignored.

Reset
REQ-032 rst high: state IDLE, counter 0, rdata 0, bus_req/bus_we/bus_be/bus_addr/bus_wdata 0, stall 0, errors 0.
REQ-033 rst mid-transaction aborts immediately; no completion, no error pulse after release.

Structure
REQ-034 Memory-mode codes, MEMORY_MODE_WIDTH and FSM state typedef belong in the shared rv32i defs package.
REQ-035 One sub-module dmem_align: combinational be/wdata lane steering and load extract/extend.

Verification
REQ-036 SW addr 0x104, wdata 0xDEADBEEF, gnt after 2 cycles -> bus_be 1111, bus_addr 0x104, stall high 3 cycles, DONE then IDLE.
REQ-037 LB addr 0x203, bus_rdata 0x80FF_1234 -> bus_be 1000, rdata 0xFFFFFF80; LBU same -> 0x00000080.
REQ-038 LH addr 0x202, bus_rdata 0x8001_0000 -> rdata 0xFFFF8001; SH wdata 0x1234 addr 0x202 -> be 1100, bus_wdata 0x12341234.
REQ-039 LW addr 0x101 -> misaligned_err 1 cycle, bus_req 0, stall 0.
REQ-040 TIMEOUT=4, gnt never -> bus_err after 4 REQ cycles, rdata 0, stall low in DONE.
REQ-041 rst asserted in WAIT_R -> outputs zero same cycle, late bus_rvalid ignored, next LW completes normally.
